// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the default bit period used by both
// the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 279;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and clears, flagging the terminal cycle
// (tick) and the cycle before it (pre_tick). Shared by the transmitter and the receiver.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    output logic [8:0] count,
    output logic       tick,
    output logic       pre_tick
);

    localparam logic [8:0] LAST_COUNT = 9'(CLKS_PER_BIT - 1);
    localparam logic [8:0] PRE_COUNT  = 9'(CLKS_PER_BIT - 2);

    assign tick     = (count == LAST_COUNT);
    assign pre_tick = (count == PRE_COUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 9'd0;
        end else if (clear || tick) begin
            count <= 9'd0;
        end else begin
            count <= count + 9'd1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter, LSB first, 1 start bit, STOP_BITS stop bits, valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_tx,
    input  logic       send,
    output logic       ready,
    output logic       dout,
    output logic       done
);

    uart_state_e state;
    logic [7:0]  shreg;
    logic [2:0]  index;
    logic        stop_idx;
    logic        last_stop;
    logic        timer_clear;
    logic [8:0]  bit_count;
    logic        tick;
    logic        pre_tick;

    assign ready     = (state == ST_IDLE);
    assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    // Held clear while idle so the start bit gets a full period; every later state
    // entry coincides with the terminal count, which clears the counter as well.
    assign timer_clear = (state == ST_IDLE) || tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .count    (bit_count),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            shreg    <= 8'd0;
            index    <= 3'd0;
            stop_idx <= 1'b0;
            dout     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (send) begin
                        shreg    <= data_tx;
                        index    <= 3'd0;
                        stop_idx <= 1'b0;
                        dout     <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        dout  <= shreg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (index == 3'd7) begin
                            index <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            dout  <= ^shreg;
                            state <= ST_PARITY;
`else
                            dout  <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            index <= index + 3'd1;
                            dout  <= shreg[3'(index + 3'd1)];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        dout  <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // done is registered, so it is raised one cycle ahead of the terminal count.
                    if (pre_tick && last_stop) begin
                        done <= 1'b1;
                    end
                    if (tick) begin
                        if (last_stop) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    dout  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
